lcd_spi_sink: RTL
=================

Name: lcd_spi_sink

Overview:
- Receive-side model of the 4-wire LCD SPI bus (lcd_clk, lcd_cs, lcd_rs, lcd_data) driven by the LCD controller.
- Oversamples the bus with the system clock and deserialises bytes.
- Decodes CASET/RASET/RAMWR and emits RGB565 pixels tagged with their x/y position.
- Used as an on-chip bus monitor and as the display model in the pixel-path simulation bench.

Parameters:
- H_RES, 240, reset value of column end + 1
- V_RES, 135, reset value of row end + 1
- CW, 9, width of the x/y coordinate registers; window values from CASET/RASET are truncated to CW bits

Ports:
- clk  in  1  system clock, 27 MHz
- resetn  in  1  asynchronous active-low reset
- lcd_clk  in  1  SPI clock from controller, idle low, data valid on rising edge, max clk/4
- lcd_cs  in  1  chip select, active low
- lcd_rs  in  1  0 = command byte, 1 = data byte
- lcd_data  in  1  serial data, MSB first
- byte_valid  out  1  one-cycle pulse per received byte
- byte_data  out  8  received byte, held until next byte
- byte_is_cmd  out  1  lcd_rs value sampled with bit 0 of the byte
- pix_valid  out  1  one-cycle pulse per completed pixel
- pix_data  out  16  RGB565 value, high byte first on wire
- pix_x  out  CW  column of pix_data
- pix_y  out  CW  row of pix_data
- frame_done  out  1  pulse coincident with pix_valid of the last pixel of the window
- err_partial  out  1  pulse when lcd_cs deasserts with 1..7 bits shifted

Behaviour:
- Reset: all outputs 0; byte_data, pix_data, pix_x, pix_y = 0; window xs=0, xe=H_RES-1, ys=0, ye=V_RES-1; FSM = IDLE; bit count 0; byte phase HI.
- Reset is asserted asynchronously. Reset mid-byte or mid-pixel discards all partial state; the first byte after release needs a fresh lcd_cs low.
- Synchronisation: 2-FF synchroniser on all four inputs. Rising edge is detected from the synced lcd_clk versus its previous value. Edges while synced lcd_cs = 1 are ignored.
- Shift: on each detected edge, shift in lcd_data and increment the 3-bit count.
- Byte delivery: on the 8th edge, the next clk cycle pulses byte_valid with byte_data and byte_is_cmd (rs sampled at the 8th edge). Pin-to-byte_valid latency is 3 clk cycles (+1 sampling jitter).
- lcd_cs rising (synced): count clears. If count was nonzero, err_partial pulses for one cycle and the partial byte is dropped. FSM state and byte phase are kept.
- Decoder FSM acts on byte_valid:
  - Any command byte resets the param index and byte phase (phase -> HI). It then transitions: 0x2A -> CASET, 0x2B -> RASET, 0x2C -> RAMWR, any other -> IDLE.
  - IDLE: data bytes are ignored.
  - CASET / RASET: param bytes 0..3 = start_hi, start_lo, end_hi, end_lo. Values are written to xs/xe (CASET) or ys/ye (RASET) when byte 3 arrives. Params beyond 3 are ignored. A command before byte 3 abandons the update; the window is unchanged.
  - RAMWR entry: x <= xs, y <= ys.
  - RAMWR data bytes: phase HI latches the high byte. Phase LO forms pix_data = {hi, lo} and pulses pix_valid with the current x, y on the cycle after byte_valid.
  - Position advance after each pixel: if x == xe, then x <= xs and, if y == ye, y <= ys with frame_done; otherwise y+1. If x != xe, x+1.
  - All coordinate arithmetic is modulo 2^CW, so xs > xe wraps through 0 deterministically.
- A dangling high byte (command arrives in phase LO) is dropped with no pixel and no error.
- byte_valid and pix_valid may pulse in the same cycle sequence; pix_valid always trails its byte_valid by exactly 1 cycle.

Decomposition:
- Shared package lcd_spi_pkg:
  - command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - decoder state enum IDLE/CASET/RASET/RAMWR
  - RGB565 field widths 5/6/5
- Sub-module lcd_spi_deser: synchroniser, edge detect, shifter, bit count, err_partial. Outputs byte_valid/byte_data/byte_is_cmd.
- Top level contains the decoder FSM and the position counters.

Test Plan:
- Reset then send cmd 0x2C, data 0xF8,0x00 at clk/4 -> one pix_valid with pix_data=16'hF800, x=0, y=0; byte_valid latency 3(+1) cycles after the 8th lcd_clk rise.
- CASET 0x00,0x28,0x00,0x2A; RASET 0x00,0x35,0x00,0x36; RAMWR with 6 pixels -> coordinates (40,53),(41,53),(42,53),(40,54),(41,54),(42,54). frame_done pulses only with the 6th, and a 7th pixel lands at (40,53).
- lcd_cs raised after 5 bits, then a full byte 0xA5 -> err_partial pulses once; the next byte_valid carries 0xA5 and the 5 stray bits are not included.
- RAMWR, one data byte 0x12, then cmd 0x00 -> no pix_valid; FSM goes to IDLE; following data bytes produce nothing.
- CASET with only 2 params then cmd 0x2C and 1 pixel -> pixel at x=0 (window unchanged, xe still 239).
- resetn pulsed low mid-pixel (after the high byte) -> all outputs 0 immediately; the next RAMWR pixel starts at (0,0) with the correct high/low pairing.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI sink: command codes, decoder states
// and RGB565 field widths.
package lcd_spi_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  typedef enum logic [1:0] {
    IDLE,
    CASET,
    RASET,
    RAMWR
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_deser.sv
// Oversampling SPI deserialiser: synchronises the bus, detects lcd_clk rises
// while selected and assembles MSB-first bytes.
module lcd_spi_deser (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_clk,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_cmd,
  output logic       err_partial
);

  logic [1:0] clk_sync;
  logic [1:0] cs_sync;
  logic [1:0] rs_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       cs_prev;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       clk_rise;
  logic       cs_rise;

  assign clk_rise = clk_sync[1] & ~clk_prev & ~cs_sync[1];
  assign cs_rise  = cs_sync[1] & ~cs_prev;

  // Chip select resets to the deselected level so release never looks like a cs edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= '0;
      cs_sync   <= 2'b11;
      rs_sync   <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], lcd_clk};
      cs_sync   <= {cs_sync[0], lcd_cs};
      rs_sync   <= {rs_sync[0], lcd_rs};
      data_sync <= {data_sync[0], lcd_data};
      clk_prev  <= clk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_is_cmd <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      err_partial <= 1'b0;
      if (cs_rise) begin
        bit_cnt     <= '0;
        err_partial <= (bit_cnt != 3'd0);
      end else if (clk_rise) begin
        shift_reg <= {shift_reg[5:0], data_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid  <= 1'b1;
          byte_data   <= {shift_reg, data_sync[1]};
          byte_is_cmd <= ~rs_sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_sink.sv
// LCD SPI bus sink: decodes CASET/RASET/RAMWR from the deserialised byte
// stream and emits RGB565 pixels tagged with their window position.
module lcd_spi_sink
  import lcd_spi_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 135,
  parameter int CW    = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lcd_clk,
  input  logic             lcd_cs,
  input  logic             lcd_rs,
  input  logic             lcd_data,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_is_cmd,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  output logic             frame_done,
  output logic             err_partial
);

  dec_state_t    state;
  dec_state_t    state_next;
  logic [2:0]    param_idx;
  logic          phase_lo;
  logic [7:0]    hi_byte;
  logic [7:0]    p_start_hi;
  logic [7:0]    p_start_lo;
  logic [7:0]    p_end_hi;
  logic [CW-1:0] xs, xe, ys, ye;
  logic [CW-1:0] x, y;

  lcd_spi_deser u_deser (
    .clk         (clk),
    .resetn      (resetn),
    .lcd_clk     (lcd_clk),
    .lcd_cs      (lcd_cs),
    .lcd_rs      (lcd_rs),
    .lcd_data    (lcd_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_is_cmd (byte_is_cmd),
    .err_partial (err_partial)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (byte_valid && byte_is_cmd) begin
      case (byte_data)
        CMD_CASET: state_next = CASET;
        CMD_RASET: state_next = RASET;
        CMD_RAMWR: state_next = RAMWR;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Window registers only change once all four parameters have arrived.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      param_idx  <= '0;
      phase_lo   <= 1'b0;
      hi_byte    <= '0;
      p_start_hi <= '0;
      p_start_lo <= '0;
      p_end_hi   <= '0;
      xs         <= '0;
      xe         <= CW'(H_RES - 1);
      ys         <= '0;
      ye         <= CW'(V_RES - 1);
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (byte_is_cmd) begin
          param_idx <= '0;
          phase_lo  <= 1'b0;
          if (byte_data == CMD_RAMWR) begin
            x <= xs;
            y <= ys;
          end
        end else begin
          case (state)
            CASET, RASET: begin
              if (param_idx != 3'd4) param_idx <= param_idx + 3'd1;
              case (param_idx)
                3'd0: p_start_hi <= byte_data;
                3'd1: p_start_lo <= byte_data;
                3'd2: p_end_hi   <= byte_data;
                3'd3: begin
                  if (state == CASET) begin
                    xs <= CW'({p_start_hi, p_start_lo});
                    xe <= CW'({p_end_hi, byte_data});
                  end else begin
                    ys <= CW'({p_start_hi, p_start_lo});
                    ye <= CW'({p_end_hi, byte_data});
                  end
                end
                default: ;
              endcase
            end
            RAMWR: begin
              if (!phase_lo) begin
                hi_byte  <= byte_data;
                phase_lo <= 1'b1;
              end else begin
                phase_lo  <= 1'b0;
                pix_valid <= 1'b1;
                pix_data  <= {hi_byte, byte_data};
                pix_x     <= x;
                pix_y     <= y;
                if (x == xe) begin
                  x <= xs;
                  if (y == ye) begin
                    y          <= ys;
                    frame_done <= 1'b1;
                  end else begin
                    y <= y + CW'(1);
                  end
                end else begin
                  x <= x + CW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
